// File: rtl/wisc_pkg.sv
// Shared WISC encodings: opcodes, branch condition codes, flag bit positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package wisc_pkg;

  // Opcodes live in instr[15:12]
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Branch condition codes live in instr[11:9]
  localparam logic [2:0] CC_NE     = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  // Bit positions inside the {Z,V,N} flag vector
  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  // Halt latch states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_state_t;

  // True for either branch form (PC-relative or register)
  function automatic logic is_branch_op(input logic [3:0] opcode);
    return (opcode == OP_B) || (opcode == OP_BR);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a 3-bit branch condition against the registered {Z,V,N} flags.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond_eval
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       cond
);

  logic flag_z;
  logic flag_v;
  logic flag_n;

  assign flag_z = flags[FLAG_Z];
  assign flag_v = flags[FLAG_V];
  assign flag_n = flags[FLAG_N];

  // Condition decode; GTE is written out literally as Z | GT
  always_comb begin
    cond = 1'b0;
    case (ccc)
      CC_NE:     cond = !flag_z;
      CC_EQ:     cond = flag_z;
      CC_GT:     cond = !flag_z && !flag_n;
      CC_LT:     cond = flag_n;
      CC_GTE:    cond = flag_z || (!flag_z && !flag_n);
      CC_LTE:    cond = flag_n || flag_z;
      CC_OVFL:   cond = flag_v;
      CC_UNCOND: cond = 1'b1;
      default:   cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_control_unit.sv
// Fetch-side PC, N/Z/V flag register and halt latch; resolves B/BR/PCS/HLT.
// Latency: one cycle from instruction to updated pc/flags/halted.
// Backpressure: none; HALT freezes pc and flags until reset.
module pc_control_unit
  import wisc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] reg_target,
  input  logic [2:0]        alu_flags,
  input  logic [2:0]        flag_wen,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus2,
  output logic              branch_taken,
  output logic [2:0]        flags,
  output logic              halted
);

  halt_state_t       state;
  halt_state_t       state_next;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] b_offset;
  logic [DATA_W-1:0] branch_target;
  logic [3:0]        opcode;
  logic [2:0]        ccc;
  logic              cond;

  assign opcode = instr[15:12];
  assign ccc    = instr[11:9];

  // Sign-extended 9-bit word offset, converted to a byte offset
  assign b_offset = {{(DATA_W-10){instr[8]}}, instr[8:0], 1'b0};

  // Both additions wrap naturally at DATA_W bits
  assign pc_plus2 = pc + DATA_W'(2);

  // BR target passes bit 0 through untouched; alignment is software's job
  assign branch_target = (opcode == OP_BR) ? reg_target : (pc_plus2 + b_offset);

  branch_cond_eval u_cond (
    .ccc   (ccc),
    .flags (flags),
    .cond  (cond)
  );

  assign halted       = (state == ST_HALT);
  assign branch_taken = is_branch_op(opcode) && cond && !halted;

  // Next-state and next-pc selection; HLT and HALT both hold the pc
  always_comb begin
    state_next = state;
    pc_next    = pc_plus2;
    case (state)
      ST_RUN: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
          pc_next    = pc;
        end else if (branch_taken) begin
          pc_next = branch_target;
        end
      end
      ST_HALT: begin
        pc_next = pc;
      end
      default: begin
        state_next = ST_RUN;
        pc_next    = pc;
      end
    endcase
  end

  // PC and halt-state registers; reset beats everything
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Flag register: per-bit write enables, frozen while halted
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags <= 3'b000;
    end else if (state == ST_RUN) begin
      flags <= (flags & ~flag_wen) | (alu_flags & flag_wen);
    end
  end

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs sampled before the next edge.
// Single check task counts every comparison and reports mismatches.
module tb_pc_control_unit;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic [15:0] reg_target;
  logic [2:0]  alu_flags;
  logic [2:0]  flag_wen;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        branch_taken;
  logic [2:0]  flags;
  logic        halted;

  int n_checks;
  int n_bad;

  pc_control_unit #(
    .DATA_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .reg_target   (reg_target),
    .alu_flags    (alu_flags),
    .flag_wen     (flag_wen),
    .pc           (pc),
    .pc_plus2     (pc_plus2),
    .branch_taken (branch_taken),
    .flags        (flags),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // BR unconditional to an absolute address (one edge)
  task automatic jump_to(input logic [15:0] addr);
    instr      = 16'hDE10;
    reg_target = addr;
    flag_wen   = 3'b000;
    step();
  endtask

  // Expected branch_taken for ccc 0..7 with flags Z=1,V=0,N=0
  logic [7:0] cc_exp_z;
  logic [15:0] b_instr;

  initial begin
    n_checks   = 0;
    n_bad      = 0;
    rst        = 1'b0;
    instr      = 16'hC1FF;
    reg_target = 16'hFFFF;
    alu_flags  = 3'b111;
    flag_wen   = 3'b111;
    cc_exp_z   = 8'b1011_0010;  // bit i = expectation for ccc=i

    // Reset held two edges with branch and flag writes pending
    step();
    step();
    check("rst_pc", pc, 16'h0000);
    check("rst_flags", {13'd0, flags}, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);

    rst       = 1'b1;
    instr     = 16'h0000;
    flag_wen  = 3'b000;
    alu_flags = 3'b000;
    #1;
    check("rst_bt", {15'd0, branch_taken}, 16'h0000);
    check("rst_pc_plus2", pc_plus2, 16'h0002);

    // Sequential wrap from 0xFFFE
    instr      = 16'hDE10;
    reg_target = 16'hFFFE;
    #1;
    check("br_wrap_bt", {15'd0, branch_taken}, 16'h0001);
    step();
    check("wrap_pc", pc, 16'hFFFE);
    check("wrap_pc_plus2", pc_plus2, 16'h0000);
    instr = 16'h0000;
    step();
    check("wrap_next_pc", pc, 16'h0000);

    // B EQ taken: set Z=1 in the same cycle as the jump to 0x0010
    instr      = 16'hDE10;
    reg_target = 16'h0010;
    flag_wen   = 3'b100;
    alu_flags  = 3'b100;
    step();
    check("beq_setup_pc", pc, 16'h0010);
    check("beq_setup_flags", {13'd0, flags}, 16'h0004);
    flag_wen = 3'b000;
    instr    = 16'hC3FC;
    #1;
    check("beq_taken_bt", {15'd0, branch_taken}, 16'h0001);
    step();
    check("beq_taken_pc", pc, 16'h000A);

    // Condition table against Z=1,V=0,N=0 (no edges)
    for (int i = 0; i < 8; i++) begin
      b_instr      = 16'hC000;
      b_instr[11:9] = i[2:0];
      instr        = b_instr;
      #1;
      check($sformatf("cc%0d_z", i), {15'd0, branch_taken}, {15'd0, cc_exp_z[i]});
    end

    // B EQ not taken: clear Z while jumping back to 0x0010
    instr      = 16'hDE10;
    reg_target = 16'h0010;
    flag_wen   = 3'b100;
    alu_flags  = 3'b000;
    step();
    check("bne_setup_flags", {13'd0, flags}, 16'h0000);
    flag_wen = 3'b000;
    instr    = 16'hC3FC;
    #1;
    check("beq_not_bt", {15'd0, branch_taken}, 16'h0000);
    step();
    check("beq_not_pc", pc, 16'h0012);

    // Flag write and B NE in one cycle: branch sees old Z=0
    instr     = 16'hC004;
    flag_wen  = 3'b100;
    alu_flags = 3'b100;
    #1;
    check("ftime_bt", {15'd0, branch_taken}, 16'h0001);
    step();
    check("ftime_pc", pc, 16'h001C);
    check("ftime_flags", {13'd0, flags}, 16'h0004);

    // Per-bit enable: write only N, Z must hold
    instr     = 16'h0000;
    flag_wen  = 3'b001;
    alu_flags = 3'b011;
    step();
    check("fwen_flags", {13'd0, flags}, 16'h0005);
    flag_wen  = 3'b000;
    alu_flags = 3'b000;

    // BR unconditional
    instr      = 16'hDE10;
    reg_target = 16'h1234;
    #1;
    check("br_bt", {15'd0, branch_taken}, 16'h0001);
    step();
    check("br_pc", pc, 16'h1234);

    // PCS at 0x0040
    jump_to(16'h0040);
    instr = 16'hE000;
    #1;
    check("pcs_pc_plus2", pc_plus2, 16'h0042);
    check("pcs_bt", {15'd0, branch_taken}, 16'h0000);
    step();
    check("pcs_next_pc", pc, 16'h0042);

    // Halt at 0x0020; flags currently 3'b101
    jump_to(16'h0020);
    instr = 16'hF000;
    step();
    check("hlt_halted", {15'd0, halted}, 16'h0001);
    check("hlt_pc", pc, 16'h0020);
    instr     = 16'hCE00;
    flag_wen  = 3'b111;
    alu_flags = 3'b010;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("hlt_bt_%0d", i), {15'd0, branch_taken}, 16'h0000);
      step();
      check($sformatf("hlt_pc_%0d", i), pc, 16'h0020);
      check($sformatf("hlt_flags_%0d", i), {13'd0, flags}, 16'h0005);
    end
    check("hlt_still_halted", {15'd0, halted}, 16'h0001);

    // One reset cycle leaves HALT
    rst = 1'b0;
    step();
    rst      = 1'b1;
    flag_wen = 3'b000;
    instr    = 16'h0000;
    check("unhalt_pc", pc, 16'h0000);
    check("unhalt_halted", {15'd0, halted}, 16'h0000);
    check("unhalt_flags", {13'd0, flags}, 16'h0000);
    step();
    check("unhalt_run_pc", pc, 16'h0002);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
